// File: rtl/sub_seq_nbit_if.sv
// Operand/result handshake bundle for the chunked subtractor.
// master = producer/consumer side, slave = subtractor.
interface sub_seq_nbit_if #(parameter int N = 64);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] IN1;
   logic [N-1:0] IN2;
   logic         Bin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] DIFF;
   logic         Bout;
   logic         ZERO;
   logic         OVF;

   modport master (
      output in_valid, IN1, IN2, Bin, out_ready,
      input  in_ready, out_valid, DIFF, Bout, ZERO, OVF
   );

   modport slave (
      input  in_valid, IN1, IN2, Bin, out_ready,
      output in_ready, out_valid, DIFF, Bout, ZERO, OVF
   );
endinterface

// File: rtl/sub_seq_nbit.sv
// Multi-cycle N-bit subtractor: DIFF = IN1 - IN2 - Bin, W bits per cycle,
// borrow carried between chunks in a register. One operation in flight.
module sub_seq_nbit #(
   parameter int N = 64,
   parameter int W = 16
) (
   input logic           CLK,
   input logic           RSTn,
   sub_seq_nbit_if.slave bus
);
   localparam int K  = N / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [N-1:0]  a, b, diff;
   logic          borrow, bout, zero, ovf;
   logic          in_ready, out_valid;
   logic [CW-1:0] cnt;

   logic [W-1:0]  a_c, b_c;
   logic [W:0]    sum;
   logic [N-1:0]  diff_nxt;
   logic          last;

   // Subtract as A + ~B + !borrow; the chunk's carry-out is the inverted borrow.
   always_comb begin
      a_c      = a[cnt*W +: W];
      b_c      = b[cnt*W +: W];
      sum      = {1'b0, a_c} + {1'b0, ~b_c} + {{W{1'b0}}, ~borrow};
      diff_nxt = diff;
      diff_nxt[cnt*W +: W] = sum[W-1:0];
      last     = (cnt == CW'(K - 1));
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state     <= IDLE;
         a         <= '0;
         b         <= '0;
         diff      <= '0;
         borrow    <= 1'b0;
         bout      <= 1'b0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready) begin
                  a        <= bus.IN1;
                  b        <= bus.IN2;
                  borrow   <= bus.Bin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               diff   <= diff_nxt;
               borrow <= ~sum[W];
               cnt    <= cnt + 1'b1;
               if (last) begin
                  // Flags come from the completed difference, so they are stable for all of DONE.
                  cnt       <= '0;
                  bout      <= ~sum[W];
                  zero      <= (diff_nxt == '0);
                  ovf       <= (a[N-1] != b[N-1]) && (diff_nxt[N-1] != a[N-1]);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.DIFF      = diff;
   assign bus.Bout      = bout;
   assign bus.ZERO      = zero;
   assign bus.OVF       = ovf;
endmodule

// File: tb/tb_sub_seq_nbit.sv
// Bench for sub_seq_nbit: directed corner cases, mid-operation reset, and
// randomized operations against an arithmetic reference.
module tb_sub_seq_nbit;
   localparam int N = 64;
   localparam int W = 16;
   localparam int K = N / W;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;
   always #5 CLK = ~CLK;

   sub_seq_nbit_if #(.N(N)) bus ();
   sub_seq_nbit #(.N(N), .W(W)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [N-1:0] diff;
      logic         bout;
      logic         zero;
      logic         ovf;
   } res_t;

   function automatic res_t ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
      res_t r;
      r.diff = x - y - N'(bi);
      r.bout = ({1'b0, x} < ({1'b0, y} + (N+1)'(bi)));
      r.zero = (r.diff == '0);
      r.ovf  = (x[N-1] != y[N-1]) && (r.diff[N-1] != x[N-1]);
      return r;
   endfunction

   function automatic logic [N-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Garbage on the operand bus while busy; optionally with in_valid pulses.
   task automatic drive_noise(input bit noise);
      bus.in_valid = noise ? 1'($urandom % 2) : 1'b0;
      bus.IN1      = rnd64();
      bus.IN2      = rnd64();
      bus.Bin      = 1'($urandom % 2);
   endtask

   // Entered and left on a falling edge.
   task automatic do_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic bi, input int hold, input bit noise);
      res_t e;
      int   n;
      e = ref_sub(x, y, bi);
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk({tag, "_in_ready"}, N'(bus.in_ready), N'(1));
      bus.in_valid = 1'b1;
      bus.IN1      = x;
      bus.IN2      = y;
      bus.Bin      = bi;
      @(negedge CLK);
      chk({tag, "_busy"}, N'(bus.in_ready), N'(0));
      n = 0;
      while (!bus.out_valid && n < 40) begin
         drive_noise(noise);
         @(negedge CLK);
         n++;
      end
      // One RUN edge per chunk before the result is presented.
      chk({tag, "_latency"}, N'(n), N'(K));
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_hold_valid"}, N'(bus.out_valid), N'(1));
         chk({tag, "_hold_rdy"}, N'(bus.in_ready), N'(0));
         chk({tag, "_hold_diff"}, bus.DIFF, e.diff);
         drive_noise(noise);
         @(negedge CLK);
      end
      chk({tag, "_valid"}, N'(bus.out_valid), N'(1));
      chk({tag, "_diff"}, bus.DIFF, e.diff);
      chk({tag, "_bout"}, N'(bus.Bout), N'(e.bout));
      chk({tag, "_zero"}, N'(bus.ZERO), N'(e.zero));
      chk({tag, "_ovf"}, N'(bus.OVF), N'(e.ovf));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge CLK);
      bus.out_ready = 1'b0;
      chk({tag, "_drop"}, N'(bus.out_valid), N'(0));
      chk({tag, "_idle"}, N'(bus.in_ready), N'(1));
   endtask

   initial begin
      logic [N-1:0] x, y;
      logic         bi;
      int           hold;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.IN1       = '0;
      bus.IN2       = '0;
      bus.Bin       = 1'b0;

      repeat (2) @(negedge CLK);
      chk("rst_in_ready", N'(bus.in_ready), N'(1));
      chk("rst_out_valid", N'(bus.out_valid), N'(0));
      chk("rst_diff", bus.DIFF, '0);
      chk("rst_bout", N'(bus.Bout), N'(0));
      chk("rst_zero", N'(bus.ZERO), N'(0));
      chk("rst_ovf", N'(bus.OVF), N'(0));
      RSTn = 1'b1;
      @(negedge CLK);

      do_op("basic", 64'h10, 64'h3, 1'b0, 0, 1'b0);
      do_op("ripple", 64'h0, 64'h1, 1'b0, 0, 1'b0);
      do_op("ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 0, 1'b0);
      do_op("zero", 64'h1234, 64'h1234, 1'b0, 0, 1'b0);
      do_op("bin_eq", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b1, 0, 1'b0);
      do_op("hold", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 10, 1'b1);

      // Reset while chunk 2 is about to be processed.
      bus.in_valid = 1'b1;
      bus.IN1      = 64'hFFFF_0000_FFFF_0000;
      bus.IN2      = 64'h0000_FFFF_0000_FFFF;
      bus.Bin      = 1'b0;
      @(negedge CLK);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge CLK);
      RSTn = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
      chk("midrst_in_ready", N'(bus.in_ready), N'(1));
      chk("midrst_out_valid", N'(bus.out_valid), N'(0));
      chk("midrst_diff", bus.DIFF, '0);
      for (int i = 0; i < K + 2; i++) begin
         @(negedge CLK);
         chk("midrst_no_result", N'(bus.out_valid), N'(0));
      end
      do_op("after_rst", 64'h5, 64'h7, 1'b1, 0, 1'b0);

      for (int i = 0; i < 4000; i++) begin
         case ($urandom % 5)
            0: begin x = rnd64(); y = x; end
            1: begin x = '0; y = N'($urandom % 4); end
            2: begin x = rnd64(); y = x + N'($urandom % 3) - N'(1); end
            3: begin x = {1'b1, 63'h0}; y = rnd64(); end
            default: begin x = rnd64(); y = rnd64(); end
         endcase
         bi   = 1'($urandom % 2);
         hold = ($urandom % 4 == 0) ? int'($urandom % 4) : 0;
         do_op("rand", x, y, bi, hold, 1'($urandom % 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
